lisa_ssa_wb_queue: RTL

LISA_SSA_WB_QUEUE -- requirements
Module: lisa_ssa_wb_queue

---
 rtl/lisa_ssa_wb_queue.sv | 109 ++++++++++
 1 files changed

// File: rtl/lisa_ssa_wb_queue.sv
// In-order writeback queue feeding one regfile write port, with a 256-entry SSA-ID ready scoreboard and a sticky duplicate-write flag.
// Latency: one cycle from acceptance to wen. With LISA_WBQ_BYPASS_EN defined, an empty queue with the port granted writes in the same cycle.
// Backpressure: in_ready is low only while the queue is full; a head entry waits in the queue until wport_gnt is high.
module lisa_ssa_wb_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_id,
    input  logic [DATA_W-1:0] in_data,
    input  logic              wport_gnt,
    output logic              wen,
    output logic [7:0]        waddr,
    output logic [DATA_W-1:0] wdata,
    input  logic              inv_valid,
    input  logic [7:0]        inv_id,
    input  logic [7:0]        qid,
    output logic              qready,
    output logic              err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_INC  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_INC  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    cnt_q, cnt_d;
    logic [255:0]      sb_q, sb_d;
    logic              err_q, err_d;
    logic [7:0]        id_mem_q  [DEPTH];
    logic [DATA_W-1:0] dat_mem_q [DEPTH];

    logic fifo_empty, fifo_full, push, pop, byp, dup;

    always_comb begin
        fifo_empty = (cnt_q == '0);
        fifo_full  = (cnt_q == CNT_FULL);
`ifdef LISA_WBQ_BYPASS_EN
        byp = rst_n && fifo_empty && wport_gnt && in_valid;
`else
        byp = 1'b0;
`endif
        // Outputs are forced to their idle values for as long as reset is held.
        in_ready = !fifo_full || !rst_n;
        pop      = rst_n && !fifo_empty && wport_gnt;
        wen      = pop || byp;
        waddr    = '0;
        wdata    = '0;
        if (rst_n && !fifo_empty) begin
            waddr = id_mem_q[rd_ptr_q];
            wdata = dat_mem_q[rd_ptr_q];
        end else if (byp) begin
            waddr = in_id;
            wdata = in_data;
        end
        push = in_valid && !fifo_full && !byp;

        wr_ptr_d = push ? wr_ptr_q + PTR_INC : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_INC : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CNT_INC;
        end else if (!push && pop) begin
            cnt_d = cnt_q - CNT_INC;
        end

        // A same-cycle invalidate of the written ID means the ID was reallocated, so it is not a duplicate.
        dup = wen && sb_q[waddr] && !(inv_valid && (inv_id == waddr));
        sb_d = sb_q;
        if (inv_valid) begin
            sb_d[inv_id] = 1'b0;
        end
        if (wen) begin
            sb_d[waddr] = 1'b1;
        end
        err_d = err_q || dup;

        qready = rst_n && sb_q[qid];
        err    = rst_n && err_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            sb_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            sb_q     <= sb_d;
            err_q    <= err_d;
        end
    end

    // Storage needs no reset: an entry is only read while the count says it is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            id_mem_q[wr_ptr_q]  <= in_id;
            dat_mem_q[wr_ptr_q] <= in_data;
        end
    end
endmodule
